rep_sequencer: RTL and testbench
================================

# rep_sequencer

Multi-cycle controller that sequences REP/REPE/REPNE-prefixed string instructions (MOVS, CMPS) through the single-step execute datapath. It accepts one decoded instruction together with its ECX/ESI/EDI/EFLAGS state and issues one execute iteration at a time over a request/done handshake. Between iterations it updates the pointers and count, and evaluates the termination condition. It sits between decode and execute. Non-string opcodes pass through as exactly one iteration.

## Interface
- `MAX_ITER`, default 1024: iteration cap; used only when `REP_ITER_LIMIT_EN` is defined.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid` / `in_ready`  in / out  1  instruction handshake.
- `in_opc`  in  6  command code (`CMD_*`).
- `in_rep`  in  2  prefix: 00 none, 01 REP/REPE, 10 REPNE, 11 treated as 00.
- `in_width`  in  2  element size: 00=1, 01=2, 10=4, 11=4 bytes.
- `in_ecx`, `in_esi`, `in_edi`, `in_eflags`  in  32 each  architectural state at issue.
- `iter_valid` / `iter_ready`  out / in  1  per-iteration request handshake.
- `iter_opc`  out  6  latched opcode.
- `iter_esi`, `iter_edi`, `iter_eflags`  out  32 each  current pointers and flags for this iteration.
- `iter_done`  in  1  one-cycle pulse: iteration result valid.
- `iter_res_eflags`  in  32  execute's `o_eflags` for the iteration.
- `out_valid` / `out_ready`  out / in  1  completion handshake.
- `out_ecx`, `out_esi`, `out_edi`, `out_eflags`  out  32 each  final state.
- `out_iters`  out  32  number of iterations performed.
- `out_trunc`  out  1  set when the iteration cap stopped the sequence.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch all inputs, clear the iteration count, go to CHECK.
- CHECK:
  - String op (MOVS/CMPS) with rep≠00 and ECX==0: go to DONE with state unchanged and iterations=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - `iter_valid`=1, held with stable outputs until `iter_ready`.
  - On handshake, go to WAIT.
- WAIT:
  - On `iter_done`, perform all of the following in the same edge:
    - EFLAGS ← `iter_res_eflags`; iterations+1.
    - For string ops, ESI and EDI each change by ±element size. The step is negative when the latched EFLAGS DF=1; the DF bit is taken before the update. Arithmetic is mod 2^32, so wrap-around is legal.
    - ECX ← ECX−1 when string op and rep≠00. This also wraps mod 2^32 but can never start at 0 (CHECK catches that).
  - Termination (go to DONE) when any of the following holds:
    - not a string op;
    - rep=00;
    - new ECX==0;
    - CMPS with rep=01 and result ZF=0;
    - CMPS with rep=10 and result ZF=1.
  - MOVS ignores ZF; rep=10 behaves as REP.
  - If not terminated, go to ISSUE.
- DONE:
  - `out_valid`=1 with stable outputs until `out_ready`, then go to IDLE.
- Non-string opcodes: one iteration; ECX, ESI and EDI are returned unchanged.
- `iter_done` outside WAIT is ignored. `iter_done` coincident with `iter_ready` in ISSUE is ignored; done is only sampled in WAIT.
- Reset (at any time, including mid-sequence):
  - State goes to IDLE; all outputs are 0 except `in_ready`, which is 1 one cycle after reset deasserts.
  - A pending `iter_done` from an aborted sequence is ignored.

## Timing
- Accept in cycle N → CHECK in N+1 → `iter_valid` in N+2.
- Zero-count REP: `out_valid` in N+2.
- `iter_done` in cycle M → next `iter_valid` or `out_valid` in M+1.
- Minimum per-iteration overhead is 1 cycle beyond the execute latency.
- `in_ready` is low from the accept cycle through the DONE handshake; no pipelining of instructions.
- `out_*` are registered and remain stable while `out_valid` and not `out_ready`.

## Configuration
- `REP_ITER_LIMIT_EN` defined:
  - After the iteration that brings the iteration count to `MAX_ITER`, go to DONE with `out_trunc`=1.
  - ECX/ESI/EDI hold the partially advanced values.
- `REP_ITER_LIMIT_EN` undefined:
  - No cap; `out_trunc` is tied to 0; the counter logic is `MAX_ITER`-independent.

## Test plan
- REP MOVS, width 4, ECX=3, ESI=0x100, EDI=0x200, DF=0, single-cycle `iter_done` → 3 requests (ESI 0x100/0x104/0x108); out ECX=0, ESI=0x10C, EDI=0x20C, iters=3.
- REP MOVS, ECX=0 → no `iter_valid`; `out_valid` 2 cycles after accept, state unchanged, iters=0.
- REPE CMPS, width 1, ECX=5, second result ZF=0 → 2 iterations, out ECX=3, ESI/EDI +2, ZF=0.
- MOVS width 2, DF=1, ESI=0x1, no prefix → 1 iteration, ESI=0xFFFFFFFF, EDI−2, ECX unchanged.
- ADD (non-string) with rep=01 and ECX=7 → 1 iteration, ECX=7, flags = `iter_res_eflags`; `out_ready` held low 3 cycles → outputs stable.
- `rst` asserted during WAIT of iteration 2, then a stray `iter_done` → IDLE, outputs 0, stray pulse ignored. With `REP_ITER_LIMIT_EN` and `MAX_ITER`=4, REP MOVS with ECX=10 → iters=4, ECX=6, `out_trunc`=1.

Source files
------------

// File: rtl/rep_sequencer_if.sv
// Handshake and data bundle between decode, rep_sequencer and the execute stage.
// The master side is the sequencer itself; the slave side is its environment
// (decode feeding in_*, execute answering iter_*, retire consuming out_*).
interface rep_sequencer_if;
    // Instruction from decode
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opc;
    logic [1:0]  in_rep;
    logic [1:0]  in_width;
    logic [31:0] in_ecx;
    logic [31:0] in_esi;
    logic [31:0] in_edi;
    logic [31:0] in_eflags;

    // Per-iteration request to execute
    logic        iter_valid;
    logic        iter_ready;
    logic [5:0]  iter_opc;
    logic [31:0] iter_esi;
    logic [31:0] iter_edi;
    logic [31:0] iter_eflags;
    logic        iter_done;
    logic [31:0] iter_res_eflags;

    // Completion towards retire
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ecx;
    logic [31:0] out_esi;
    logic [31:0] out_edi;
    logic [31:0] out_eflags;
    logic [31:0] out_iters;
    logic        out_trunc;

    modport master (
        input  in_valid, in_opc, in_rep, in_width, in_ecx, in_esi, in_edi, in_eflags,
        output in_ready,
        output iter_valid, iter_opc, iter_esi, iter_edi, iter_eflags,
        input  iter_ready, iter_done, iter_res_eflags,
        output out_valid, out_ecx, out_esi, out_edi, out_eflags, out_iters, out_trunc,
        input  out_ready
    );

    modport slave (
        output in_valid, in_opc, in_rep, in_width, in_ecx, in_esi, in_edi, in_eflags,
        input  in_ready,
        input  iter_valid, iter_opc, iter_esi, iter_edi, iter_eflags,
        output iter_ready, iter_done, iter_res_eflags,
        input  out_valid, out_ecx, out_esi, out_edi, out_eflags, out_iters, out_trunc,
        output out_ready
    );
endinterface

// File: rtl/rep_sequencer.sv
// rep_sequencer: walks REP/REPE/REPNE string instructions (MOVS, CMPS) through
// the single-step execute datapath one iteration at a time, updating ECX/ESI/EDI
// and EFLAGS between iterations. Non-string opcodes run exactly one iteration.
//
// Optional feature: define REP_ITER_LIMIT_EN to cap a sequence at MAX_ITER
// iterations; the capped result is flagged with out_trunc.
module rep_sequencer #(
    parameter int unsigned MAX_ITER = 1024
) (
    input logic           clk,
    input logic           rst,
    rep_sequencer_if.master bus
);

    localparam logic [5:0] CMD_MOVS = 6'd20;
    localparam logic [5:0] CMD_CMPS = 6'd21;

    localparam int unsigned DF_BIT = 10;
    localparam int unsigned ZF_BIT = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  opc_r;
    logic [1:0]  rep_r;
    logic [1:0]  width_r;
    logic [31:0] ecx_r;
    logic [31:0] esi_r;
    logic [31:0] edi_r;
    logic [31:0] eflags_r;
    logic [31:0] iters_r;
    logic        in_ready_r;
    logic        iter_valid_r;
    logic        out_valid_r;

    // Decoded properties of the latched instruction
    logic        is_str;
    logic        is_cmps;
    logic        rep_on;
    logic [31:0] step;

    // Values the architectural state takes when the current iteration retires
    logic [31:0] ecx_nxt;
    logic [31:0] esi_nxt;
    logic [31:0] edi_nxt;
    logic [31:0] iters_nxt;
    logic        res_zf;
    logic        stop_nat;

`ifdef REP_ITER_LIMIT_EN
    logic        trunc_r;
    logic        cap_hit;
`else
    // Keeps the cap parameter referenced in the uncapped build.
    localparam int unsigned unused_max_iter = MAX_ITER;
`endif

    // Per-iteration update and natural termination condition
    always_comb begin
        is_str    = (opc_r == CMD_MOVS) || (opc_r == CMD_CMPS);
        is_cmps   = (opc_r == CMD_CMPS);
        rep_on    = (rep_r == 2'b01) || (rep_r == 2'b10);
        step      = (width_r == 2'b00) ? 32'd1 :
                    (width_r == 2'b01) ? 32'd2 : 32'd4;
        res_zf    = bus.iter_res_eflags[ZF_BIT];
        iters_nxt = iters_r + 32'd1;
        esi_nxt   = esi_r;
        edi_nxt   = edi_r;
        ecx_nxt   = ecx_r;
        if (is_str) begin
            // Direction comes from the flags held before this iteration's update.
            if (eflags_r[DF_BIT]) begin
                esi_nxt = esi_r - step;
                edi_nxt = edi_r - step;
            end else begin
                esi_nxt = esi_r + step;
                edi_nxt = edi_r + step;
            end
            if (rep_on) begin
                ecx_nxt = ecx_r - 32'd1;
            end
        end
        stop_nat = !is_str || !rep_on || (ecx_nxt == 32'd0) ||
                   (is_cmps && (rep_r == 2'b01) && !res_zf) ||
                   (is_cmps && (rep_r == 2'b10) && res_zf);
`ifdef REP_ITER_LIMIT_EN
        cap_hit  = (iters_nxt == 32'(MAX_ITER));
`endif
    end

    // Sequencer FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            opc_r        <= '0;
            rep_r        <= '0;
            width_r      <= '0;
            ecx_r        <= '0;
            esi_r        <= '0;
            edi_r        <= '0;
            eflags_r     <= '0;
            iters_r      <= '0;
            in_ready_r   <= 1'b0;
            iter_valid_r <= 1'b0;
            out_valid_r  <= 1'b0;
`ifdef REP_ITER_LIMIT_EN
            trunc_r      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        opc_r      <= bus.in_opc;
                        rep_r      <= bus.in_rep;
                        width_r    <= bus.in_width;
                        ecx_r      <= bus.in_ecx;
                        esi_r      <= bus.in_esi;
                        edi_r      <= bus.in_edi;
                        eflags_r   <= bus.in_eflags;
                        iters_r    <= '0;
`ifdef REP_ITER_LIMIT_EN
                        trunc_r    <= 1'b0;
`endif
                        in_ready_r <= 1'b0;
                        state      <= S_CHECK;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                S_CHECK: begin
                    // A repeated string op with a zero count does no work at all.
                    if (is_str && rep_on && (ecx_r == 32'd0)) begin
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        iter_valid_r <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // iter_done is not looked at here, even alongside iter_ready.
                    if (bus.iter_ready) begin
                        iter_valid_r <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.iter_done) begin
                        eflags_r <= bus.iter_res_eflags;
                        iters_r  <= iters_nxt;
                        esi_r    <= esi_nxt;
                        edi_r    <= edi_nxt;
                        ecx_r    <= ecx_nxt;
                        if (stop_nat) begin
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end
`ifdef REP_ITER_LIMIT_EN
                        else if (cap_hit) begin
                            trunc_r     <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end
`endif
                        else begin
                            iter_valid_r <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.iter_valid  = iter_valid_r;
    assign bus.iter_opc    = opc_r;
    assign bus.iter_esi    = esi_r;
    assign bus.iter_edi    = edi_r;
    assign bus.iter_eflags = eflags_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_ecx     = ecx_r;
    assign bus.out_esi     = esi_r;
    assign bus.out_edi     = edi_r;
    assign bus.out_eflags  = eflags_r;
    assign bus.out_iters   = iters_r;
`ifdef REP_ITER_LIMIT_EN
    assign bus.out_trunc   = trunc_r;
`else
    assign bus.out_trunc   = 1'b0;
`endif

endmodule

// File: tb/tb_rep_sequencer.sv
// Directed testbench for rep_sequencer: drives instructions, plays the role of
// a single-cycle execute stage and checks the final architectural state.
module tb_rep_sequencer;

    localparam logic [5:0] CMD_ADD  = 6'd1;
    localparam logic [5:0] CMD_MOVS = 6'd20;
    localparam logic [5:0] CMD_CMPS = 6'd21;

`ifdef REP_ITER_LIMIT_EN
    localparam int unsigned MAX_ITER_TB = 4;
`else
    localparam int unsigned MAX_ITER_TB = 1024;
`endif

    logic clk;
    logic rst;

    rep_sequencer_if bus ();

    rep_sequencer #(.MAX_ITER(MAX_ITER_TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] res_tab  [0:15];
    logic [31:0] seen_esi [0:15];
    logic [31:0] seen_edi [0:15];
    logic [31:0] seen_fl  [0:15];
    logic [5:0]  seen_opc [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_res();
        for (int i = 0; i < 16; i++) res_tab[i] = 32'h0;
    endtask

    // Issue one instruction and serve its iterations until out_valid appears.
    task automatic run_instr(input logic [5:0] opc, input logic [1:0] rep, input logic [1:0] width,
                             input logic [31:0] ecx, input logic [31:0] esi, input logic [31:0] edi,
                             input logic [31:0] flags, input int rdy_delay, input bit early_done,
                             output int n_iter);
        int  guard;
        bit  fin;
        bus.in_opc    = opc;
        bus.in_rep    = rep;
        bus.in_width  = width;
        bus.in_ecx    = ecx;
        bus.in_esi    = esi;
        bus.in_edi    = edi;
        bus.in_eflags = flags;
        bus.in_valid  = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("accept_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("check_cycle_quiet", 32'(bus.iter_valid | bus.out_valid), 32'd0);
        tick();
        n_iter = 0;
        fin    = 1'b0;
        guard  = 0;
        while (!fin && guard < 40) begin
            guard++;
            if (bus.out_valid) begin
                fin = 1'b1;
            end else if (bus.iter_valid) begin
                for (int d = 0; d < rdy_delay; d++) begin
                    tick();
                    chk("iter_valid_held", 32'(bus.iter_valid), 32'd1);
                end
                if (n_iter < 16) begin
                    seen_esi[n_iter] = bus.iter_esi;
                    seen_edi[n_iter] = bus.iter_edi;
                    seen_fl[n_iter]  = bus.iter_eflags;
                    seen_opc[n_iter] = bus.iter_opc;
                end
                bus.iter_ready = 1'b1;
                if (early_done) begin
                    bus.iter_done       = 1'b1;
                    bus.iter_res_eflags = 32'h0000_0000;
                end
                tick();
                bus.iter_ready = 1'b0;
                bus.iter_done  = 1'b0;
                chk("iter_valid_drop", 32'(bus.iter_valid), 32'd0);
                bus.iter_done       = 1'b1;
                bus.iter_res_eflags = res_tab[n_iter % 16];
                tick();
                bus.iter_done = 1'b0;
                n_iter++;
            end else begin
                chk("next_step_latency", 32'(bus.iter_valid | bus.out_valid), 32'd1);
                fin = 1'b1;
            end
        end
        if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [31:0] ecx, input logic [31:0] esi,
                             input logic [31:0] edi, input logic [31:0] fl, input logic [31:0] iters,
                             input logic trunc);
        chk({tag, "_ecx"},    bus.out_ecx,    ecx);
        chk({tag, "_esi"},    bus.out_esi,    esi);
        chk({tag, "_edi"},    bus.out_edi,    edi);
        chk({tag, "_eflags"}, bus.out_eflags, fl);
        chk({tag, "_iters"},  bus.out_iters,  iters);
        chk({tag, "_trunc"},  32'(bus.out_trunc), 32'(trunc));
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid        = 1'b0;
        bus.in_opc          = '0;
        bus.in_rep          = '0;
        bus.in_width        = '0;
        bus.in_ecx          = '0;
        bus.in_esi          = '0;
        bus.in_edi          = '0;
        bus.in_eflags       = '0;
        bus.iter_ready      = 1'b0;
        bus.iter_done       = 1'b0;
        bus.iter_res_eflags = '0;
        bus.out_ready       = 1'b0;
        clear_res();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready",   32'(bus.in_ready),   32'd0);
        chk("rst_iter_valid", 32'(bus.iter_valid), 32'd0);
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_out_ecx",    bus.out_ecx,         32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // REP MOVS dword, three iterations upward
        clear_res();
        res_tab[0] = 32'h2; res_tab[1] = 32'h2; res_tab[2] = 32'h2;
        run_instr(CMD_MOVS, 2'b01, 2'b10, 32'd3, 32'h100, 32'h200, 32'h0, 0, 1'b0, n);
        chk("movs_req_count", 32'(n), 32'd3);
        chk("movs_opc",  32'(seen_opc[0]), 32'(CMD_MOVS));
        chk("movs_esi0", seen_esi[0], 32'h100);
        chk("movs_esi1", seen_esi[1], 32'h104);
        chk("movs_esi2", seen_esi[2], 32'h108);
        chk("movs_edi2", seen_edi[2], 32'h208);
        chk("movs_in_ready_busy", 32'(bus.in_ready), 32'd0);
        check_out("movs", 32'd0, 32'h10C, 32'h20C, 32'h2, 32'd3, 1'b0);
        retire("movs");

        // REP MOVS with zero count: no iterations at all
        run_instr(CMD_MOVS, 2'b01, 2'b00, 32'd0, 32'h55, 32'h66, 32'h400, 0, 1'b0, n);
        chk("zero_req_count", 32'(n), 32'd0);
        check_out("zero", 32'd0, 32'h55, 32'h66, 32'h400, 32'd0, 1'b0);
        retire("zero");

        // REPE CMPS byte, mismatch on second compare; stalled ready and stray early done
        clear_res();
        res_tab[0] = 32'h40; res_tab[1] = 32'h0;
        run_instr(CMD_CMPS, 2'b01, 2'b00, 32'd5, 32'h1000, 32'h2000, 32'h0, 2, 1'b1, n);
        chk("repe_req_count", 32'(n), 32'd2);
        chk("repe_esi1", seen_esi[1], 32'h1001);
        chk("repe_fl1",  seen_fl[1],  32'h40);
        check_out("repe", 32'd3, 32'h1002, 32'h2002, 32'h0, 32'd2, 1'b0);
        retire("repe");

        // REPNE CMPS word, match on second compare
        clear_res();
        res_tab[0] = 32'h0; res_tab[1] = 32'h40;
        run_instr(CMD_CMPS, 2'b10, 2'b01, 32'd4, 32'h10, 32'h20, 32'h0, 0, 1'b0, n);
        check_out("repne", 32'd2, 32'h14, 32'h24, 32'h40, 32'd2, 1'b0);
        retire("repne");

        // Unprefixed MOVS word with DF=1 wraps ESI below zero
        clear_res();
        res_tab[0] = 32'h400;
        run_instr(CMD_MOVS, 2'b00, 2'b01, 32'd9, 32'h1, 32'h300, 32'h400, 0, 1'b0, n);
        check_out("movs_df", 32'd9, 32'hFFFF_FFFF, 32'h2FE, 32'h400, 32'd1, 1'b0);
        retire("movs_df");

        // Non-string ADD with a REP prefix; completion held for three cycles
        clear_res();
        res_tab[0] = 32'h8D5;
        run_instr(CMD_ADD, 2'b01, 2'b10, 32'd7, 32'h30, 32'h40, 32'h0, 0, 1'b0, n);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("add_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("add_hold_eflags", bus.out_eflags, 32'h8D5);
            chk("add_hold_ecx", bus.out_ecx, 32'd7);
        end
        check_out("add", 32'd7, 32'h30, 32'h40, 32'h8D5, 32'd1, 1'b0);
        retire("add");

        // Reset during the second iteration's wait, followed by a stray done
        bus.in_opc = CMD_MOVS; bus.in_rep = 2'b01; bus.in_width = 2'b10;
        bus.in_ecx = 32'd5; bus.in_esi = 32'h40; bus.in_edi = 32'h80; bus.in_eflags = 32'h0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("abort_iter1_valid", 32'(bus.iter_valid), 32'd1);
        bus.iter_ready = 1'b1;
        tick();
        bus.iter_ready = 1'b0;
        bus.iter_done = 1'b1; bus.iter_res_eflags = 32'h0;
        tick();
        bus.iter_done = 1'b0;
        chk("abort_iter2_esi", bus.iter_esi, 32'h44);
        bus.iter_ready = 1'b1;
        tick();
        bus.iter_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        bus.iter_done = 1'b1; bus.iter_res_eflags = 32'hFFFF_FFFF;
        tick();
        bus.iter_done = 1'b0;
        chk("abort_in_ready",   32'(bus.in_ready),   32'd1);
        chk("abort_iter_valid", 32'(bus.iter_valid), 32'd0);
        chk("abort_out_valid",  32'(bus.out_valid),  32'd0);
        check_out("abort", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("abort_still_idle", 32'(bus.iter_valid | bus.out_valid), 32'd0);

        // Long REP MOVS: capped when the limit is built in, runs to zero otherwise
        clear_res();
`ifdef REP_ITER_LIMIT_EN
        run_instr(CMD_MOVS, 2'b01, 2'b00, 32'd10, 32'h0, 32'h10, 32'h0, 0, 1'b0, n);
        check_out("cap", 32'd6, 32'h4, 32'h14, 32'h0, 32'd4, 1'b1);
        retire("cap");
`else
        run_instr(CMD_MOVS, 2'b01, 2'b00, 32'd10, 32'h0, 32'h10, 32'h0, 0, 1'b0, n);
        check_out("long", 32'd0, 32'hA, 32'h1A, 32'h0, 32'd10, 1'b0);
        retire("long");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
